ddr3_multiport_arbiter: RTL and testbench
=========================================

// Module: ddr3_multiport_arbiter
// PURPOSE
//  Parametrised N-port front end to the MIG 7-series app/wdf interface; replaces the single-client ram_reader path after SD load.
//  Each client issues aligned BL8 read/write requests of CLIENT_W bits with byte enables.
//  Round-robin arbitration feeds the MIG command and write-data FIFOs.
//  Up to RD_TAG_DEPTH reads are in flight; read data is steered back to the issuing port.
// PARAMETERS
//  NUM_PORTS       2    number of client ports (1..8)
//  ADDR_WIDTH      27   MIG app_addr width
//  APP_DATA_WIDTH  64   MIG app_wdf_data/app_rd_data width
//  BURST_BEATS     2    app beats per request; CLIENT_W = APP_DATA_WIDTH*BURST_BEATS, BE_W = CLIENT_W/8
//  RD_TAG_DEPTH    4    max outstanding reads (power of 2)
// PORTS
//  clk                 in   1                    MIG ui_clk; sole clock
//  reset               in   1                    synchronous, active-high
//  init_calib_complete in   1                    no grants while low
//  port_req            in   NUM_PORTS            request, held until port_ack
//  port_we             in   NUM_PORTS            1=write 0=read, per port
//  port_addr           in   NUM_PORTS*ADDR_WIDTH packed per port
//  port_wdata          in   NUM_PORTS*CLIENT_W   packed per port
//  port_wbytes         in   NUM_PORTS*BE_W       1=write byte
//  port_ack            out  NUM_PORTS            1-cycle pulse, command accepted by MIG
//  port_rdata          out  CLIENT_W             shared read-return bus
//  port_rvalid         out  NUM_PORTS            one-hot 1-cycle pulse, port_rdata valid for that port
//  rd_orphan_err       out  1                    sticky: read data arrived with tag FIFO empty
//  app_addr/app_cmd/app_en            out  ADDR_WIDTH/3/1  MIG command
//  app_rdy                            in   1
//  app_wdf_data/app_wdf_mask          out  APP_DATA_WIDTH/APP_DATA_WIDTH/8 (1=mask)
//  app_wdf_wren/app_wdf_end           out  1/1
//  app_wdf_rdy                        in   1
//  app_rd_data/app_rd_data_valid/app_rd_data_end  in  APP_DATA_WIDTH/1/1
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, RR pointer 0, tag FIFO empty, beat counters 0, rd_orphan_err cleared.
//  FSM: IDLE -> (calib && any eligible req) latch winner addr/data/be/we -> WR_DATA if we else RD_CMD.
//   WR_DATA: beat k = wdata[k*APP_DATA_WIDTH +: APP_DATA_WIDTH], beat 0 = LSBs; wren high until wdf_rdy; wdf_end on last beat; -> WR_CMD.
//   WR_CMD: app_cmd=3'b000, app_en high until app_rdy; accept cycle pulses port_ack[winner]; -> IDLE.
//   RD_CMD: app_cmd=3'b001, app_en until app_rdy; accept pushes winner index to tag FIFO, pulses port_ack; -> IDLE.
//  app_addr = latched addr with [2:0] forced 0 (BL8 alignment). app_wdf_mask = ~wbytes slice.
//  Eligible: port_req && (port_we || tag FIFO not full). Read blocked when full; a write from another port may win.
//  RR: search from pointer; after grant, pointer = winner+1 mod NUM_PORTS. Min 1 idle cycle between grants.
//  Read return: on rd_data_valid store beat at beat counter; on last beat (app_rd_data_end) pop tag.
//   Next cycle: port_rdata = assembled word, port_rvalid[tag]=1. Pop and push in same cycle both apply.
//  Valid with FIFO empty: data dropped, rd_orphan_err=1 until reset.
//  Ordering: MIG strict ordering; commands issued in grant order, reads return in issue order.
//  Reset mid-burst: abandons write beats and tags; clients must also be reset.
//  Client must hold req/we/addr/wdata/wbytes stable until port_ack; deassert req cycle after ack.
//  Latency: req -> app_en <= 2 cycles (read); last rd beat -> port_rvalid 1 cycle.
// CONFIGURATION
//  ARB_PRIORITY_EN defined: port 0 strict priority when eligible.
//   RR among ports 1..NUM_PORTS-1; a port 0 grant leaves the pointer unchanged.
//  ARB_PRIORITY_EN undefined: pure round-robin over all ports.
// TESTING
//  1 port0 write addr 0x100, wdata {64'hA,64'hB}, wbytes 16'hFFFF
//     -> beats 64'hB then 64'hA, mask 0, end on beat 2, cmd 000 @0x100, port_ack[0] once.
//  2 port1 write addr 0x10F, wbytes 16'h00F0 -> app_addr 0x108, beat0 mask 8'h0F, beat1 mask 8'hFF.
//  3 both ports read every cycle, RR
//     -> grants alternate 0,1,0,1; responses 64'h1/64'h2 -> port_rdata {2,1}, correct one-hot rvalid, in issue order.
//  4 app_rdy low 20 cycles with 4 reads pending on RD_TAG_DEPTH=4
//     -> 5th read held, no app_en; a port write still issues; read issues after 1 return.
//  5 app_wdf_rdy toggling 1/0 -> each beat held until accepted, data unchanged.
//  6 init_calib_complete=0 -> no ack. Reset mid-read -> all outputs 0; next orphan beat sets rd_orphan_err.
//     With ARB_PRIORITY_EN: port0 continuous -> port1 starved.

Source files
------------

// File: rtl/ddr3_multiport_arbiter.sv
// ddr3_multiport_arbiter: round-robin N-port BL8 front end to the MIG app/wdf interface with tagged read return.
// Define ARB_PRIORITY_EN to give port 0 strict priority over the round-robin ports.
module ddr3_multiport_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = 27,
  parameter int APP_DATA_WIDTH = 64,
  parameter int BURST_BEATS = 2,
  parameter int RD_TAG_DEPTH = 4,
  localparam int CLIENT_W = APP_DATA_WIDTH * BURST_BEATS,
  localparam int BE_W = CLIENT_W / 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init_calib_complete,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS-1:0]            port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*CLIENT_W-1:0]   port_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]       port_wbytes,
  output logic [NUM_PORTS-1:0]            port_ack,
  output logic [CLIENT_W-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]            port_rvalid,
  output logic                            rd_orphan_err,
  output logic [ADDR_WIDTH-1:0]           app_addr,
  output logic [2:0]                      app_cmd,
  output logic                            app_en,
  input  logic                            app_rdy,
  output logic [APP_DATA_WIDTH-1:0]       app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0]     app_wdf_mask,
  output logic                            app_wdf_wren,
  output logic                            app_wdf_end,
  input  logic                            app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]       app_rd_data,
  input  logic                            app_rd_data_valid,
  input  logic                            app_rd_data_end
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int TW = RD_TAG_DEPTH > 1 ? $clog2(RD_TAG_DEPTH) : 1;
  localparam int BW = BURST_BEATS > 1 ? $clog2(BURST_BEATS) : 1;
  localparam int MW = APP_DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, WR_DATA, WR_CMD, RD_CMD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, gnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CLIENT_W-1:0] wdata_q, rbuf_q, rbuf_d, rdata_q;
  logic [BE_W-1:0] wbytes_q;
  logic [BW-1:0] beat_q, beat_d, rbeat_q;
  logic [PW-1:0] tag_mem_q [RD_TAG_DEPTH];
  logic [TW-1:0] wp_q, rp_q;
  logic [TW:0] cnt_q;
  logic [NUM_PORTS-1:0] elig, rr_elig, rvalid_q;
  logic orphan_q, found, grant, full, push, pop, beat_ok, wdf_last;
  assign full = cnt_q == (TW+1)'(RD_TAG_DEPTH);
  assign elig = port_req & (port_we | {NUM_PORTS{~full}});
`ifdef ARB_PRIORITY_EN
  assign rr_elig = elig & ~NUM_PORTS'(1);
`else
  assign rr_elig = elig;
`endif
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (!found && rr_elig[PW'((int'(ptr_q) + i) % NUM_PORTS)]) begin
        found = 1'b1;
        gnt = PW'((int'(ptr_q) + i) % NUM_PORTS);
      end
    ptr_d = gnt == PW'(NUM_PORTS - 1) ? '0 : gnt + 1'b1;
`ifdef ARB_PRIORITY_EN
    if (elig[0]) begin
      found = 1'b1;
      gnt = '0;
      ptr_d = ptr_q;
    end
`endif
  end
  assign grant = state_q == IDLE && init_calib_complete && found;
  assign wdf_last = beat_q == BW'(BURST_BEATS - 1);
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    case (state_q)
      IDLE: state_d = grant ? (port_we[gnt] ? WR_DATA : RD_CMD) : IDLE;
      WR_DATA: if (app_wdf_rdy) begin
        beat_d = wdf_last ? '0 : beat_q + 1'b1;
        state_d = wdf_last ? WR_CMD : WR_DATA;
      end
      default: state_d = app_rdy ? IDLE : state_q;
    endcase
  end
  assign app_en = state_q == WR_CMD || state_q == RD_CMD;
  assign app_cmd = state_q == RD_CMD ? 3'b001 : 3'b000;
  assign app_addr = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign app_wdf_wren = state_q == WR_DATA;
  assign app_wdf_end = app_wdf_wren && wdf_last;
  assign app_wdf_data = wdata_q[beat_q*APP_DATA_WIDTH +: APP_DATA_WIDTH];
  assign app_wdf_mask = app_wdf_wren ? ~wbytes_q[beat_q*MW +: MW] : '0;
  assign port_ack = (app_en && app_rdy) ? NUM_PORTS'(1) << win_q : '0;
  assign push = state_q == RD_CMD && app_rdy;
  assign beat_ok = app_rd_data_valid && cnt_q != '0;
  assign pop = beat_ok && app_rd_data_end;
  assign port_rdata = rdata_q;
  assign port_rvalid = rvalid_q;
  assign rd_orphan_err = orphan_q;
  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[rbeat_q*APP_DATA_WIDTH +: APP_DATA_WIDTH] = app_rd_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wbytes_q <= '0;
      beat_q <= '0;
      rbeat_q <= '0;
      rbuf_q <= '0;
      rdata_q <= '0;
      rvalid_q <= '0;
      orphan_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      if (grant) begin
        ptr_q <= ptr_d;
        win_q <= gnt;
        addr_q <= port_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= port_wdata[gnt*CLIENT_W +: CLIENT_W];
        wbytes_q <= port_wbytes[gnt*BE_W +: BE_W];
      end
      if (beat_ok) begin
        rbuf_q <= rbuf_d;
        rbeat_q <= app_rd_data_end ? '0 : rbeat_q + 1'b1;
      end
      rvalid_q <= pop ? NUM_PORTS'(1) << tag_mem_q[rp_q] : '0;
      if (pop) rdata_q <= rbuf_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (TW+1)'(push) - (TW+1)'(pop);
      if (app_rd_data_valid && cnt_q == '0) orphan_q <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) tag_mem_q[wp_q] <= win_q;
endmodule

// File: tb/tb_ddr3_multiport_arbiter.sv
// tb_ddr3_multiport_arbiter: directed self-checking bench for ddr3_multiport_arbiter (2 ports, 64-bit app, BL8).
module tb_ddr3_multiport_arbiter;
  localparam int NP = 2, AW = 27, DW = 64, CW = 128, BW = 16;
`ifdef ARB_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, init_calib_complete = 1'b1;
  logic [NP-1:0] port_req = '0, port_we = '0, port_ack, port_rvalid;
  logic [NP*AW-1:0] port_addr = '0;
  logic [NP*CW-1:0] port_wdata = '0;
  logic [NP*BW-1:0] port_wbytes = '0;
  logic [CW-1:0] port_rdata;
  logic rd_orphan_err, app_en, app_wdf_wren, app_wdf_end;
  logic app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0, app_rd_data_end = 1'b0;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  logic [DW-1:0] app_wdf_data, app_rd_data = '0;
  logic [7:0] app_wdf_mask;
  logic [NP-1:0] acks [4];
  int na;
  int tests = 0, fails = 0;
  ddr3_multiport_arbiter dut (
    .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_wbytes(port_wbytes), .port_ack(port_ack),
    .port_rdata(port_rdata), .port_rvalid(port_rvalid), .rd_orphan_err(rd_orphan_err),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ret(input logic [63:0] b0, input logic [63:0] b1, input logic [1:0] v);
    app_rd_data_valid = 1'b1;
    app_rd_data = b0;
    app_rd_data_end = 1'b0;
    tick;
    app_rd_data = b1;
    app_rd_data_end = 1'b1;
    tick;
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    check("ret_rvalid", port_rvalid, v);
    check("ret_rdata", port_rdata, {b1, b0});
    tick;
    check("ret_rvalid_pulse", port_rvalid, 2'b00);
  endtask
  initial begin
    tick;
    tick;
    check("rst_app_en", app_en, 0);
    check("rst_ack", port_ack, 0);
    check("rst_rvalid", port_rvalid, 0);
    check("rst_rdata", port_rdata, 0);
    check("rst_wren", app_wdf_wren, 0);
    check("rst_mask", app_wdf_mask, 0);
    check("rst_orphan", rd_orphan_err, 0);
    reset = 1'b0;
    app_wdf_rdy = 1'b1;
    port_req = 2'b01;
    port_we = 2'b01;
    port_addr[0 +: AW] = 27'h100;
    port_wdata[0 +: CW] = {64'hA, 64'hB};
    port_wbytes[0 +: BW] = 16'hFFFF;
    check("t1_idle_wren", app_wdf_wren, 0);
    tick;
    check("t1_b0_data", app_wdf_data, 64'hB);
    check("t1_b0_mask", app_wdf_mask, 8'h00);
    check("t1_b0_end", app_wdf_end, 0);
    tick;
    check("t1_b1_data", app_wdf_data, 64'hA);
    check("t1_b1_end", app_wdf_end, 1);
    tick;
    check("t1_en", app_en, 1);
    check("t1_cmd", app_cmd, 3'b000);
    check("t1_addr", app_addr, 27'h100);
    check("t1_wren_off", app_wdf_wren, 0);
    check("t1_ack_wait", port_ack, 2'b00);
    app_rdy = 1'b1;
    #1;
    check("t1_ack", port_ack, 2'b01);
    tick;
    port_req = 2'b00;
    port_we = 2'b00;
    check("t1_ack_once", port_ack, 2'b00);
    check("t1_en_off", app_en, 0);
    port_req = 2'b10;
    port_we = 2'b10;
    port_addr[AW +: AW] = 27'h10F;
    port_wdata[CW +: CW] = {64'h2222, 64'h1111};
    port_wbytes[BW +: BW] = 16'h00F0;
    tick;
    check("t2_b0_data", app_wdf_data, 64'h1111);
    check("t2_b0_mask", app_wdf_mask, 8'h0F);
    tick;
    check("t2_b1_data", app_wdf_data, 64'h2222);
    check("t2_b1_mask", app_wdf_mask, 8'hFF);
    check("t2_b1_end", app_wdf_end, 1);
    tick;
    check("t2_en", app_en, 1);
    check("t2_addr", app_addr, 27'h108);
    check("t2_ack", port_ack, 2'b10);
    port_req = 2'b00;
    port_we = 2'b00;
    tick;
    check("t2_en_off", app_en, 0);
    port_addr[0 +: AW] = 27'h200;
    port_addr[AW +: AW] = 27'h300;
    port_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t3_en", app_en, 1);
      check("t3_cmd", app_cmd, 3'b001);
      check("t3_ack", port_ack, (PRI || i % 2 == 0) ? 2'b01 : 2'b10);
      check("t3_addr", app_addr, (PRI || i % 2 == 0) ? 27'h200 : 27'h300);
      tick;
      check("t3_gap", app_en, 0);
    end
    app_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      check("t4_full_hold", app_en, 0);
    end
    port_we = 2'b10;
    port_addr[AW +: AW] = 27'h400;
    port_wdata[CW +: CW] = {64'h44, 64'h33};
    port_wbytes[BW +: BW] = 16'hFFFF;
    tick;
    check("t4_wr_b0", app_wdf_data, 64'h33);
    tick;
    check("t4_wr_b1", app_wdf_data, 64'h44);
    tick;
    check("t4_wr_en", app_en, 1);
    check("t4_wr_addr", app_addr, 27'h400);
    check("t4_wr_ack_wait", port_ack, 2'b00);
    tick;
    check("t4_wr_stall", app_en, 1);
    app_rdy = 1'b1;
    #1;
    check("t4_wr_ack", port_ack, 2'b10);
    tick;
    port_req = 2'b01;
    port_we = 2'b00;
    check("t4_rd_blocked0", app_en, 0);
    tick;
    check("t4_rd_blocked1", app_en, 0);
    ret(64'h1, 64'h2, 2'b01);
    check("t4_rd_issue", app_en, 1);
    check("t4_rd_addr", app_addr, 27'h200);
    check("t4_rd_ack", port_ack, 2'b01);
    port_req = 2'b00;
    tick;
    ret(64'h3, 64'h4, PRI ? 2'b01 : 2'b10);
    ret(64'h5, 64'h6, 2'b01);
    check("t6_no_orphan", rd_orphan_err, 0);
    app_rd_data_valid = 1'b1;
    app_rd_data = 64'hB0;
    tick;
    reset = 1'b1;
    app_rd_data_valid = 1'b0;
    tick;
    reset = 1'b0;
    check("t6_rst_en", app_en, 0);
    check("t6_rst_addr", app_addr, 0);
    check("t6_rst_rdata", port_rdata, 0);
    check("t6_rst_rvalid", port_rvalid, 0);
    check("t6_rst_orphan", rd_orphan_err, 0);
    app_rd_data_valid = 1'b1;
    app_rd_data = 64'hB1;
    app_rd_data_end = 1'b1;
    tick;
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    check("t6_orphan", rd_orphan_err, 1);
    check("t6_orphan_drop", port_rvalid, 0);
    tick;
    tick;
    check("t6_orphan_sticky", rd_orphan_err, 1);
    init_calib_complete = 1'b0;
    port_req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t6_calib_en", app_en, 0);
      check("t6_calib_ack", port_ack, 0);
    end
    init_calib_complete = 1'b1;
    tick;
    check("t6_calib_go", port_ack, 2'b01);
    port_req = 2'b00;
    tick;
    app_wdf_rdy = 1'b0;
    port_req = 2'b01;
    port_we = 2'b01;
    port_wdata[0 +: CW] = {64'hCC, 64'hDD};
    tick;
    check("t5_b0", app_wdf_data, 64'hDD);
    tick;
    check("t5_b0_hold", app_wdf_data, 64'hDD);
    check("t5_b0_wren", app_wdf_wren, 1);
    app_wdf_rdy = 1'b1;
    tick;
    check("t5_b1", app_wdf_data, 64'hCC);
    check("t5_b1_end", app_wdf_end, 1);
    app_wdf_rdy = 1'b0;
    tick;
    check("t5_b1_hold", app_wdf_data, 64'hCC);
    check("t5_b1_wren", app_wdf_wren, 1);
    app_wdf_rdy = 1'b1;
    tick;
    check("t5_ack", port_ack, 2'b01);
    port_req = 2'b00;
    port_we = 2'b00;
    tick;
    port_req = 2'b11;
    port_we = 2'b11;
    na = 0;
    for (int i = 0; i < 60 && na < 4; i++) begin
      tick;
      if (port_ack != 2'b00) begin
        acks[na] = port_ack;
        na++;
      end
    end
    port_req = 2'b00;
    port_we = 2'b00;
    check("t7_ack_count", na, 4);
    for (int i = 0; i < na; i++)
      check("t7_arb", acks[i], PRI ? 2'b01 : (i % 2 == 0 ? 2'b10 : 2'b01));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
